// File: rtl/inv_cipher_aes_round.sv
// ---------------------------------------------------------------------------
// inv_cipher_aes_round
//   One registered round of the AES inverse cipher (equivalent ordering):
//     out = InvSubBytes(InvShiftRows([InvMixColumns](in ^ round_key)))
//   A chain of these, fed round keys Nr..1, forms the decryptor core; the
//   final XOR with round key 0 is left to the parent.
//
// Ports
//   clk            clock, rising edge
//   resetn         asynchronous active-low reset
//   aes_in_tdata   input state, byte 0 = bits[127:120], bytes fill columns
//   aes_in_tvalid  input beat valid
//   aes_in_tlast   input last-of-packet marker, travels with its beat
//   aes_in_tready  block can accept a beat
//   round_key      round key (same byte order), sampled on accepting edge
//   aes_out_tdata  registered round result
//   aes_out_tvalid output beat valid
//   aes_out_tlast  tlast of the beat in the output register
//   aes_out_tready downstream ready
//
// Parameter
//   MIX_COLUMNS_EN  1: apply InvMixColumns after AddRoundKey; 0: skip it
// ---------------------------------------------------------------------------
module inv_cipher_aes_round #(
    parameter int unsigned MIX_COLUMNS_EN = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [127:0] aes_in_tdata,
    input  logic         aes_in_tvalid,
    input  logic         aes_in_tlast,
    output logic         aes_in_tready,
    input  logic [127:0] round_key,
    output logic [127:0] aes_out_tdata,
    output logic         aes_out_tvalid,
    output logic         aes_out_tlast,
    input  logic         aes_out_tready
);

    // GF(2^8) multiply, reduction polynomial 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] res;
        logic [7:0] sq;
        res = 8'h01;
        sq  = a;
        for (int unsigned i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            res = gmul(res, sq);
        end
        return res;
    endfunction

    // Inverse S-box: inverse affine transform, then GF inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return ginv(t);
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] din,
                                              input logic [127:0] key);
        logic [7:0]   a [16];
        logic [7:0]   m [16];
        logic [127:0] dout;
        for (int unsigned k = 0; k < 16; k++)
            a[k] = din[127 - 8*k -: 8] ^ key[127 - 8*k -: 8];
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                if (MIX_COLUMNS_EN != 0)
                    m[4*c + r] = gmul(a[4*c + r],             8'h0e)
                               ^ gmul(a[4*c + ((r + 1) % 4)], 8'h0b)
                               ^ gmul(a[4*c + ((r + 2) % 4)], 8'h0d)
                               ^ gmul(a[4*c + ((r + 3) % 4)], 8'h09);
                else
                    m[4*c + r] = a[4*c + r];
            end
        end
        // InvShiftRows and InvSubBytes fused: byte (r,c) lands at (r,(c+r)%4)
        dout = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                dout[127 - 8*(4*((c + r) % 4) + r) -: 8] = inv_sbox(m[4*c + r]);
        return dout;
    endfunction

    logic [127:0] round_out;

    always_comb begin
        round_out     = round_fn(aes_in_tdata, round_key);
        aes_in_tready = !aes_out_tvalid || aes_out_tready;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aes_out_tdata  <= '0;
            aes_out_tvalid <= 1'b0;
            aes_out_tlast  <= 1'b0;
        end else if (aes_in_tready) begin
            aes_out_tvalid <= aes_in_tvalid;
            // tlast only travels with a real beat
            aes_out_tlast  <= aes_in_tvalid && aes_in_tlast;
            if (aes_in_tvalid)
                aes_out_tdata <= round_out;
        end
    end

endmodule

// File: tb/tb_inv_cipher_aes_round.sv
module tb_inv_cipher_aes_round;

    logic         clk;
    logic         resetn;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic [127:0] key;
    logic         out_ready;

    logic [127:0] d0_data, d1_data;
    logic         d0_valid, d1_valid, d0_last, d1_last, d0_ready, d1_ready;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Standalone rounds: without and with InvMixColumns
    inv_cipher_aes_round #(.MIX_COLUMNS_EN(0)) dut0 (
        .clk(clk), .resetn(resetn),
        .aes_in_tdata(in_data), .aes_in_tvalid(in_valid), .aes_in_tlast(in_last),
        .aes_in_tready(d0_ready), .round_key(key),
        .aes_out_tdata(d0_data), .aes_out_tvalid(d0_valid), .aes_out_tlast(d0_last),
        .aes_out_tready(out_ready)
    );

    inv_cipher_aes_round #(.MIX_COLUMNS_EN(1)) dut1 (
        .clk(clk), .resetn(resetn),
        .aes_in_tdata(in_data), .aes_in_tvalid(in_valid), .aes_in_tlast(in_last),
        .aes_in_tready(d1_ready), .round_key(key),
        .aes_out_tdata(d1_data), .aes_out_tvalid(d1_valid), .aes_out_tlast(d1_last),
        .aes_out_tready(out_ready)
    );

    // Fourteen-round AES-256 decryption chain
    logic [127:0] rk [15];
    logic [127:0] ch_data;
    logic         ch_valid, ch_last;
    logic [127:0] sd [15];
    logic         sv [15];
    logic         sl [15];
    logic         sr [15];

    assign sd[0]  = ch_data;
    assign sv[0]  = ch_valid;
    assign sl[0]  = ch_last;
    assign sr[14] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < 14; g++) begin : g_chain
            inv_cipher_aes_round #(.MIX_COLUMNS_EN((g == 0) ? 0 : 1)) u_round (
                .clk(clk), .resetn(resetn),
                .aes_in_tdata(sd[g]), .aes_in_tvalid(sv[g]), .aes_in_tlast(sl[g]),
                .aes_in_tready(sr[g]), .round_key(rk[14 - g]),
                .aes_out_tdata(sd[g + 1]), .aes_out_tvalid(sv[g + 1]),
                .aes_out_tlast(sl[g + 1]), .aes_out_tready(sr[g + 1])
            );
        end
    endgenerate

    // Key schedule helpers (forward S-box built by brute-force inverse search)
    logic [7:0] sbox [256];

    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic build_tables();
        logic [255:0] k256;
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [7:0]   rcon;
        logic [7:0]   inv;
        logic [7:0]   x;
        for (int i = 0; i < 256; i++) begin
            x   = 8'(i);
            inv = 8'h00;
            for (int j = 1; j < 256; j++)
                if (tb_gmul(x, 8'(j)) == 8'h01) inv = 8'(j);
            sbox[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        k256 = 256'h603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4;
        for (int i = 0; i < 8; i++) w[i] = k256[255 - 32*i -: 32];
        rcon = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i - 1];
            if (i % 8 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = tb_gmul(rcon, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i - 8] ^ t;
        end
        for (int r = 0; r < 15; r++)
            rk[r] = {w[4*r], w[4*r + 1], w[4*r + 2], w[4*r + 3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] ALL52 = {16{8'h52}};
    localparam logic [127:0] ALL63 = {16{8'h63}};
    localparam logic [127:0] ROT_EXP = 128'h00000000000100000000000000000000;

    logic [127:0] pat7c;
    logic [127:0] ct [5];
    logic [127:0] pt [5];
    int           nout;
    int           first_edge;
    logic         gap;

    initial begin
        resetn    = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        key       = '0;
        out_ready = 1'b1;
        ch_data   = '0;
        ch_valid  = 1'b0;
        ch_last   = 1'b0;
        pat7c     = ALL63;
        pat7c[119:112] = 8'h7C;
        build_tables();

        #12;
        chk("rst_valid", 128'(d0_valid), 128'd0);
        chk("rst_last",  128'(d0_last),  128'd0);
        chk("rst_data",  d0_data,        '0);
        chk("rst_ready", 128'(d0_ready), 128'd1);
        resetn = 1'b1;
        step();

        // Basic transform vectors
        in_data = '0; in_valid = 1'b1;
        step();
        chk("zero_mc0",   d0_data,         ALL52);
        chk("zero_valid", 128'(d0_valid),  128'd1);
        in_data = ALL63;
        step();
        chk("uniform_mc1", d1_data, '0);
        in_data = pat7c;
        step();
        chk("shiftrows_row1", d0_data, ROT_EXP);

        // Backpressure: hold while downstream is stalled
        in_valid = 1'b0;
        step();
        chk("idle_valid", 128'(d0_valid), 128'd0);
        out_ready = 1'b0;
        in_data = '0; in_valid = 1'b1; in_last = 1'b1;
        step();
        chk("bp_loaded",  128'(d0_valid), 128'd1);
        chk("bp_ready0",  128'(d0_ready), 128'd0);
        in_data = ALL63; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_data",  d0_data,         ALL52);
            chk("bp_hold_valid", 128'(d0_valid),  128'd1);
            chk("bp_hold_last",  128'(d0_last),   128'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready1", 128'(d0_ready), 128'd1);
        step();
        chk("bp_replace_data", d0_data,        '0);
        chk("bp_replace_last", 128'(d0_last),  128'd0);
        in_valid = 1'b0;
        step();
        chk("bp_drained", 128'(d0_valid), 128'd0);

        // Five-beat burst, tlast on beat 5 only
        for (int b = 0; b < 5; b++) begin
            in_valid = 1'b1;
            in_last  = (b == 4);
            case (b)
                0: begin in_data = '0;    key = '0;    end
                1: begin in_data = ALL63; key = '0;    end
                2: begin in_data = '0;    key = ALL63; end
                3: begin in_data = pat7c; key = '0;    end
                default: begin in_data = ALL63; key = ALL63; end
            endcase
            step();
            case (b)
                0: chk("burst_b0", d0_data, ALL52);
                1: chk("burst_b1", d0_data, '0);
                2: chk("burst_b2", d0_data, '0);
                3: chk("burst_b3", d0_data, ROT_EXP);
                default: chk("burst_b4", d0_data, ALL52);
            endcase
            chk("burst_valid", 128'(d0_valid), 128'd1);
            chk("burst_last",  128'(d0_last),  128'(b == 4));
        end
        in_valid = 1'b0; in_last = 1'b0; key = '0;
        step();
        chk("burst_end", 128'(d0_valid), 128'd0);

        // Asynchronous reset while a beat is held
        out_ready = 1'b0;
        in_data = '0; in_valid = 1'b1; in_last = 1'b1;
        step();
        chk("prerst_valid", 128'(d0_valid), 128'd1);
        in_valid = 1'b0; in_last = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_valid", 128'(d0_valid), 128'd0);
        chk("async_rst_last",  128'(d0_last),  128'd0);
        chk("async_rst_data",  d0_data,        '0);
        chk("async_rst_ready", 128'(d0_ready), 128'd1);
        #2 resetn = 1'b1;
        out_ready = 1'b1;
        step();
        chk("postrst_valid", 128'(d0_valid), 128'd0);

        // AES-256 chain, five beats back-to-back, tlast on the fifth
        ct[0] = 128'hF3EED1BDB5D2A03C064B5A7E3DB181F8;
        ct[1] = 128'h591CCB10D410ED26DC5BA74A31362870;
        ct[2] = ct[0]; ct[3] = ct[1]; ct[4] = ct[0];
        pt[0] = 128'h6BC1BEE22E409F96E93D7E117393172A;
        pt[1] = 128'hAE2D8A571E03AC9C9EB76FAC45AF8E51;
        pt[2] = pt[0]; pt[3] = pt[1]; pt[4] = pt[0];
        nout = 0;
        first_edge = -1;
        gap = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc < 5) begin
                ch_data  = ct[cyc];
                ch_valid = 1'b1;
                ch_last  = (cyc == 4);
            end else begin
                ch_valid = 1'b0;
                ch_last  = 1'b0;
            end
            step();
            if (sv[14]) begin
                if (first_edge < 0) first_edge = cyc + 1;
                if (cyc + 1 != first_edge + nout) gap = 1'b1;
                if (nout < 5) begin
                    chk("chain_plain", sd[14] ^ rk[0], pt[nout]);
                    chk("chain_last",  128'(sl[14]),   128'(nout == 4));
                end
                nout++;
            end
        end
        chk("chain_latency", 128'(first_edge), 128'd14);
        chk("chain_count",   128'(nout),       128'd5);
        chk("chain_b2b",     128'(gap),        128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
